// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronizes the SPI pins into sysClk, assembles
// MSB-first bytes with frame position, shifts a status byte out on MISO.
module spi_slave_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_BYTES   = 9
) (
    input  logic       sysClk,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    input  logic [7:0] tx_status,
    output logic [7:0] spi_byte,
    output logic       spi_input_valid,
    output logic [3:0] spi_byte_num,
    output logic       frame_active,
    output logic       frame_done,
    output logic       frame_error
);

    localparam logic [3:0] MAX_B = 4'(MAX_BYTES);

    typedef enum logic {IDLE, ACTIVE} state_t;

    // Synchronizer chains; the last stage is the synchronized value.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic                   sclk_hist_q, cs_hist_q;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [3:0] byte_cnt_q, byte_cnt_d;
    logic       overrun_q, overrun_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       miso_q, miso_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d;
    logic [3:0] num_q, num_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs_n};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        byte_cnt_d = byte_cnt_q;
        overrun_d  = overrun_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        miso_d     = miso_q;
        byte_d     = byte_q;
        num_d      = num_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    bit_cnt_d  = 3'd0;
                    tx_cnt_d   = 3'd0;
                    byte_cnt_d = 4'd0;
                    overrun_d  = 1'b0;
                    tx_sr_d    = tx_status;
                    miso_d     = tx_status[7];
                end
            end
            ACTIVE: begin
                // CS deassert takes priority over a coincident SCLK edge, so a
                // byte completing in that same cycle is treated as partial.
                if (cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    if (bit_cnt_q != 3'd0 || byte_cnt_q != MAX_B || overrun_q)
                        err_d = 1'b1;
                    else
                        done_d = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        rx_sr_d   = {rx_sr_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_d  = {rx_sr_q[6:0], mosi_s};
                            num_d   = byte_cnt_q;
                            valid_d = 1'b1;
                            if (byte_cnt_q >= MAX_B) overrun_d = 1'b1;
                            if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
                        end
                    end
                    if (sclk_fall) begin
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd7) begin
                            tx_sr_d = tx_status;
                            miso_d  = tx_status[7];
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                            miso_d  = tx_sr_q[6];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sync chains reset low so a CS already asserted at reset release never
    // looks like a falling edge; that frame is skipped until CS cycles.
    always_ff @(posedge sysClk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            tx_cnt_q    <= 3'd0;
            byte_cnt_q  <= 4'd0;
            overrun_q   <= 1'b0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            miso_q      <= 1'b0;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            num_q       <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            overrun_q   <= overrun_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            byte_q      <= byte_d;
            valid_q     <= valid_d;
            num_q       <= num_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign frame_active    = (state_q == ACTIVE) ? ~cs_rise : cs_fall;
    assign spi_miso        = miso_q;
    assign spi_byte        = byte_q;
    assign spi_input_valid = valid_q;
    assign spi_byte_num    = num_q;
    assign frame_done      = done_q;
    assign frame_error     = err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives an SPI master model and compares strobes,
// MISO bytes and frame results against a frame-level reference model.
module tb_spi_slave_rx;

    localparam int HALF = 8;  // sysClk cycles per SCLK phase

    logic       sysClk = 1'b0;
    logic       reset_n = 1'b0;
    logic       spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
    logic       spi_miso;
    logic [7:0] tx_status = 8'h00;
    logic [7:0] spi_byte;
    logic       spi_input_valid;
    logic [3:0] spi_byte_num;
    logic       frame_active, frame_done, frame_error;

    int checks = 0, failures = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [11:0] got_q[$];
    logic [7:0] frm_data[0:31];
    logic [7:0] frm_stat[0:32];
    logic [7:0] frm_miso[0:31];
    logic act_mid, act_end;

    spi_slave_rx #(.SYNC_STAGES(2), .MAX_BYTES(9)) dut (
        .sysClk(sysClk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .tx_status(tx_status),
        .spi_byte(spi_byte), .spi_input_valid(spi_input_valid), .spi_byte_num(spi_byte_num),
        .frame_active(frame_active), .frame_done(frame_done), .frame_error(frame_error)
    );

    always #5 sysClk = ~sysClk;

    always @(negedge sysClk) begin
        if (spi_input_valid) got_q.push_back({spi_byte_num, spi_byte});
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
        if (frame_done && frame_error) both_cnt++;
    end

    // Reference model: k-th whole byte is reported with index min(k,15).
    function automatic logic [11:0] exp_strobe(input int k);
        return {(k > 15) ? 4'd15 : 4'(k), frm_data[k]};
    endfunction

    function automatic bit exp_done(input int nwhole, input int partial, input bit collide);
        return (partial == 0) && !collide && (nwhole == 9);
    endfunction

    task automatic wait_half();
        repeat (HALF) @(negedge sysClk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input logic [7:0] next_status,
                             output logic [7:0] miso_b);
        miso_b = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            wait_half();
            spi_sclk = 1'b1;
            miso_b[7-i] = spi_miso;
            if (i == 0) tx_status = next_status;
            wait_half();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 32; k++) frm_data[k] = 8'($urandom);
        for (int k = 0; k < 33; k++) frm_stat[k] = 8'($urandom);
    endtask

    task automatic clear_mon();
        got_q.delete();
        done_cnt = 0; err_cnt = 0; both_cnt = 0;
    endtask

    task automatic run_frame(input int nwhole, input int partial, input bit collide);
        logic [7:0] m;
        clear_mon();
        tx_status = frm_stat[0];
        spi_cs_n = 1'b0;
        wait_half();
        act_mid = frame_active;
        for (int k = 0; k < nwhole; k++) begin
            send_bits(frm_data[k], 8, frm_stat[k+1], m);
            frm_miso[k] = m;
        end
        if (partial > 0) send_bits(frm_data[nwhole], partial, 8'h00, m);
        if (collide) begin
            send_bits(frm_data[nwhole], 7, 8'h00, m);
            spi_mosi = frm_data[nwhole][0];
            wait_half();
            spi_sclk = 1'b1;
            spi_cs_n = 1'b1;
            wait_half();
            spi_sclk = 1'b0;
        end else begin
            wait_half();
            spi_cs_n = 1'b1;
        end
        repeat (12) @(negedge sysClk);
        act_end = frame_active;
    endtask

    task automatic check_frame(input string name, input int nwhole, input int partial, input bit collide);
        bit d = exp_done(nwhole, partial, collide);
        checks++;
        if (got_q.size() != nwhole) begin
            failures++;
            $display("FAIL %s strobe_count got=%0d exp=%0d", name, got_q.size(), nwhole);
        end
        for (int k = 0; k < got_q.size() && k < nwhole; k++) begin
            checks++;
            if (got_q[k] !== exp_strobe(k)) begin
                failures++;
                $display("FAIL %s strobe[%0d] got=%h exp=%h", name, k, got_q[k], exp_strobe(k));
            end
        end
        checks++;
        if (done_cnt !== (d ? 1 : 0) || err_cnt !== (d ? 0 : 1) || both_cnt !== 0) begin
            failures++;
            $display("FAIL %s result done=%0d err=%0d both=%0d exp_done=%0d", name, done_cnt, err_cnt, both_cnt, d);
        end
        checks++;
        if (act_mid !== 1'b1 || act_end !== 1'b0) begin
            failures++;
            $display("FAIL %s frame_active mid=%b end=%b exp 1/0", name, act_mid, act_end);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({spi_miso, spi_byte, spi_input_valid, spi_byte_num, frame_active, frame_done, frame_error} !== 17'h0) begin
            failures++;
            $display("FAIL %s outputs miso=%b byte=%h vld=%b num=%0d act=%b done=%b err=%b exp all 0",
                     name, spi_miso, spi_byte, spi_input_valid, spi_byte_num, frame_active, frame_done, frame_error);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysClk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge sysClk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_nominal();
        fill_random();
        frm_data[0] = 8'hA5;
        for (int k = 1; k < 9; k++) frm_data[k] = 8'(k);
        run_frame(9, 0, 1'b0);
        check_frame("nominal", 9, 0, 1'b0);
    endtask

    task automatic test_miso();
        fill_random();
        frm_stat[0] = 8'hC3;
        frm_stat[1] = 8'h3C;
        run_frame(9, 0, 1'b0);
        check_frame("miso_frame", 9, 0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (frm_miso[k] !== frm_stat[k]) begin
                failures++;
                $display("FAIL miso byte%0d got=%h exp=%h", k, frm_miso[k], frm_stat[k]);
            end
        end
    endtask

    task automatic test_partial();
        fill_random();
        run_frame(2, 5, 1'b0);
        check_frame("partial", 2, 5, 1'b0);
    endtask

    task automatic test_overrun();
        fill_random();
        run_frame(17, 0, 1'b0);
        check_frame("overrun", 17, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int nw = $urandom_range(1, 12);
            int pb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            if (f == 0) begin nw = 9; pb = 0; end
            fill_random();
            run_frame(nw, pb, 1'b0);
            check_frame("random", nw, pb, 1'b0);
            for (int k = 0; k < nw; k++) begin
                checks++;
                if (frm_miso[k] !== frm_stat[k]) begin
                    failures++;
                    $display("FAIL random_miso byte%0d got=%h exp=%h", k, frm_miso[k], frm_stat[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        fill_random();
        clear_mon();
        tx_status = frm_stat[0];
        spi_cs_n = 1'b0;
        wait_half();
        for (int k = 0; k < 3; k++) send_bits(frm_data[k], 8, frm_stat[k+1], m);
        send_bits(frm_data[3], 4, frm_stat[4], m);
        checks++;
        if (got_q.size() != 3 || frame_active !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid pre strobes=%0d act=%b exp 3/1", got_q.size(), frame_active);
        end
        @(negedge sysClk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        repeat (3) @(negedge sysClk);
        reset_n = 1'b1;
        clear_mon();
        for (int k = 4; k < 7; k++) send_bits(frm_data[k], 8, 8'h00, m);
        wait_half();
        spi_cs_n = 1'b1;
        repeat (12) @(negedge sysClk);
        checks++;
        if (got_q.size() != 0 || done_cnt != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid ignored strobes=%0d done=%0d err=%0d exp 0", got_q.size(), done_cnt, err_cnt);
        end
        fill_random();
        run_frame(9, 0, 1'b0);
        check_frame("after_reset", 9, 0, 1'b0);
    endtask

    task automatic test_ignored();
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom);
            wait_half();
            spi_sclk = 1'b1;
            wait_half();
            spi_sclk = 1'b0;
        end
        repeat (12) @(negedge sysClk);
        checks++;
        if (got_q.size() != 0 || done_cnt != 0 || err_cnt != 0 || frame_active !== 1'b0) begin
            failures++;
            $display("FAIL ignored strobes=%0d done=%0d err=%0d act=%b exp 0", got_q.size(), done_cnt, err_cnt, frame_active);
        end
    endtask

    task automatic test_collision();
        fill_random();
        run_frame(9, 0, 1'b1);
        check_frame("collision9", 9, 0, 1'b1);
        fill_random();
        run_frame(3, 0, 1'b1);
        check_frame("collision3", 3, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_miso();
        test_partial();
        test_overrun();
        test_reset_mid();
        test_ignored();
        test_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
